// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter between N_REQ byte sources.
// Define UART_ARB_LOCK_EN to keep a grant across bytes until req_last or a lock timeout.
module uart_tx_arbiter #(
  parameter int N_REQ        = 2,
  parameter int LOCK_TIMEOUT = 255,
  parameter int ID_W         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  input  logic               tx_ready,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy
);

`ifdef UART_ARB_LOCK_EN
  typedef enum logic [1:0] {IDLE, XFER, LOCK} state_t;
  localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             last_reg, last_next;
`else
  typedef enum logic [0:0] {IDLE, XFER} state_t;
  logic [31:0] unused_lock;
  assign unused_lock = 32'(LOCK_TIMEOUT) ^ 32'(req_last);
`endif

  state_t          state_reg, state_next;
  logic [ID_W-1:0] last_ptr_reg, last_ptr_next;
  logic [ID_W-1:0] grant_reg, grant_next;
  logic [7:0]      data_reg, data_next;

  logic [7:0] data_arr [N_REQ];
  logic       last_arr [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_split
      assign data_arr[gi] = req_data[8*gi +: 8];
      assign last_arr[gi] = req_last[gi];
    end
  endgenerate

  // Round-robin search: scan downward so the candidate nearest last_ptr+1 is written last.
  logic            win_found;
  logic [ID_W-1:0] win_id;
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = int'(last_ptr_reg) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req_valid[ID_W'(idx)]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  logic            take;
  logic [ID_W-1:0] take_id;

  always_comb begin
    state_next    = state_reg;
    last_ptr_next = last_ptr_reg;
    grant_next    = grant_reg;
    data_next     = data_reg;
    req_ready     = '0;
    take          = 1'b0;
    take_id       = win_id;
`ifdef UART_ARB_LOCK_EN
    last_next     = last_reg;
    cnt_next      = '0;
`endif
    case (state_reg)
      IDLE: begin
        take    = win_found;
        take_id = win_id;
      end
      XFER: begin
        if (tx_ready) begin
`ifdef UART_ARB_LOCK_EN
          if (!last_reg) begin
            state_next = LOCK;
          end else begin
            last_ptr_next = grant_reg;
            state_next    = IDLE;
          end
`else
          last_ptr_next = grant_reg;
          state_next    = IDLE;
`endif
        end
      end
`ifdef UART_ARB_LOCK_EN
      LOCK: begin
        if (req_valid[grant_reg]) begin
          take    = 1'b1;
          take_id = grant_reg;
        end else if (cnt_reg == CNT_W'(LOCK_TIMEOUT - 1)) begin
          last_ptr_next = grant_reg;
          state_next    = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase

    // An acceptance during reset would be silently lost, so none is signalled.
    if (take && !reset) begin
      req_ready[take_id] = 1'b1;
      data_next          = data_arr[take_id];
      grant_next         = take_id;
      state_next         = XFER;
`ifdef UART_ARB_LOCK_EN
      last_next          = last_arr[take_id];
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      last_ptr_reg <= ID_W'(N_REQ - 1);
      grant_reg    <= '0;
      data_reg     <= '0;
`ifdef UART_ARB_LOCK_EN
      last_reg     <= 1'b0;
      cnt_reg      <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      last_ptr_reg <= last_ptr_next;
      grant_reg    <= grant_next;
      data_reg     <= data_next;
`ifdef UART_ARB_LOCK_EN
      last_reg     <= last_next;
      cnt_reg      <= cnt_next;
`endif
    end
  end

  assign tx_valid = (state_reg == XFER);
  assign tx_data  = data_reg;
  assign grant_id = grant_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int N    = 2;
  localparam int T    = 20;
  localparam int ID_W = 1;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_valid;
  logic [7:0]     tx_data;
  logic           tx_ready;
  logic [ID_W-1:0] grant_id;
  logic           busy;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.N_REQ(N), .LOCK_TIMEOUT(T), .ID_W(ID_W)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .grant_id(grant_id), .busy(busy)
  );

  always #5 clock = ~clock;

  // Reference arbitration rule: first valid requester after ptr, wrapping.
  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; req_valid = '0; req_data = '0; req_last = '1; tx_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 2'b11; req_data = {8'hB0, 8'hA0}; req_last = '1; tx_ready = 1'b0;
    repeat (2) begin
      @(negedge clock); #1;
      checks++;
      if (req_ready !== 2'b00) begin
        errors++; $display("FAIL reset_ready: got %b expected 00", req_ready);
      end
      checks++;
      if ({tx_valid, tx_data, grant_id, busy} !== '0) begin
        errors++; $display("FAIL reset_outputs: tx_valid=%b tx_data=%h grant_id=%0d busy=%b expected all 0",
                           tx_valid, tx_data, grant_id, busy);
      end
    end
    reset = 1'b0; #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL reset_first_grant: req_ready=%b expected 01", req_ready);
    end
    @(negedge clock); #1;
    checks++;
    if (grant_id !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'hA0) begin
      errors++; $display("FAIL reset_first_xfer: grant_id=%0d tx_valid=%b tx_data=%h expected 0 1 a0",
                         grant_id, tx_valid, tx_data);
    end
    $display("test_reset done: first byte %h from requester %0d", tx_data, grant_id);
  endtask

  task automatic test_round_robin();
    logic [7:0] got [$];
    logic [7:0] exp_seq [4];
    int na, nb;
    logic prev_v;
    exp_seq = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
    do_reset();
    na = 0; nb = 0; prev_v = 1'b0; tx_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && got.size() < 4; cyc++) begin
      req_valid = 2'b11;
      req_data  = {8'(8'hB0 + nb), 8'(8'hA0 + na)};
      #1;
      checks++;
      if (tx_valid && prev_v) begin
        errors++; $display("FAIL rr_gap: tx_valid high two cycles in a row at cycle %0d (expected gap)", cyc);
      end
      if (tx_valid && tx_ready) got.push_back(tx_data);
      if (req_ready[0]) na++;
      if (req_ready[1]) nb++;
      prev_v = tx_valid;
      @(negedge clock);
    end
    checks++;
    if (got.size() != 4) begin
      errors++; $display("FAIL rr_count: got %0d bytes expected 4 within 20 cycles", got.size());
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_seq[i]) begin
        errors++; $display("FAIL rr_byte%0d: got %h expected %h", i, got[i], exp_seq[i]);
      end
      $display("rr byte %0d: %h", i, got[i]);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 2'b10; req_data = {8'h55, 8'h11}; tx_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++; $display("FAIL bp_grant: req_ready=%b expected 10", req_ready);
    end
    @(negedge clock);
    req_valid = 2'b11; req_data = {8'h77, 8'h11};
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h55 || busy !== 1'b1) begin
        errors++; $display("FAIL bp_hold: cycle %0d tx_valid=%b tx_data=%h busy=%b expected 1 55 1",
                           cyc, tx_valid, tx_data, busy);
      end
      checks++;
      if (req_ready !== 2'b00) begin
        errors++; $display("FAIL bp_ready: cycle %0d req_ready=%b expected 00", cyc, req_ready);
      end
      @(negedge clock);
    end
    tx_ready = 1'b1; #1;
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h55) begin
      errors++; $display("FAIL bp_complete: tx_valid=%b tx_data=%h expected 1 55", tx_valid, tx_data);
    end
    @(negedge clock);
    tx_ready = 1'b0; #1;
    checks++;
    if (tx_valid !== 1'b0 || req_ready !== 2'b01) begin
      errors++; $display("FAIL bp_after: tx_valid=%b req_ready=%b expected 0 01", tx_valid, req_ready);
    end
    $display("test_backpressure done: 0x55 held 10 cycles");
  endtask

  task automatic test_reset_xfer();
    do_reset();
    req_valid = 2'b01; req_data = {8'h00, 8'h3C}; tx_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL rx_grant: req_ready=%b expected 01", req_ready);
    end
    @(negedge clock);
    req_valid = 2'b00; #1;
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h3C) begin
      errors++; $display("FAIL rx_pending: tx_valid=%b tx_data=%h expected 1 3c", tx_valid, tx_data);
    end
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0; #1;
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++; $display("FAIL rx_drop: tx_valid=%b expected 0 after reset", tx_valid);
    end
    tx_ready = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clock); #1;
      checks++;
      if (tx_valid !== 1'b0) begin
        errors++; $display("FAIL rx_never: cycle %0d tx_valid=%b tx_data=%h expected no byte", cyc, tx_valid, tx_data);
      end
    end
    $display("test_reset_xfer done: pending 0x3C discarded");
  endtask

`ifndef UART_ARB_LOCK_EN
  task automatic test_random();
    logic [N-1:0]    src_v;
    logic [7:0]      src_d [N];
    logic [N-1:0]    exp_ready;
    logic [ID_W-1:0] exp_gid;
    logic            m_hold;
    logic [7:0]      m_byte;
    int m_ptr, m_gid, w, sent;
    do_reset();
    src_v = '0; m_hold = 1'b0; m_byte = '0; m_ptr = N - 1; m_gid = 0; sent = 0;
    for (int i = 0; i < N; i++) src_d[i] = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!src_v[i] && $urandom_range(0, 2) == 0) begin
          src_v[i] = 1'b1; src_d[i] = 8'($urandom);
        end else if (src_v[i] && $urandom_range(0, 15) == 0) begin
          src_v[i] = 1'b0;
        end
        req_data[8*i +: 8] = src_d[i];
      end
      req_valid = src_v;
      tx_ready  = 1'($urandom_range(0, 1));
      #1;
      w = m_hold ? -1 : rr_pick(req_valid, m_ptr);
      exp_ready = '0;
      if (w >= 0) exp_ready[w] = 1'b1;
      exp_gid = ID_W'(m_gid);
      checks++;
      if (req_ready !== exp_ready) begin
        errors++; $display("FAIL rand_ready: cycle %0d got %b expected %b", cyc, req_ready, exp_ready);
      end
      checks++;
      if (tx_valid !== m_hold || busy !== m_hold || grant_id !== exp_gid) begin
        errors++; $display("FAIL rand_state: cycle %0d tx_valid=%b busy=%b grant_id=%0d expected %b %b %0d",
                           cyc, tx_valid, busy, grant_id, m_hold, m_hold, exp_gid);
      end
      if (m_hold) begin
        checks++;
        if (tx_data !== m_byte) begin
          errors++; $display("FAIL rand_data: cycle %0d got %h expected %h", cyc, tx_data, m_byte);
        end
      end
      if (m_hold) begin
        if (tx_ready) begin
          m_hold = 1'b0; m_ptr = m_gid; sent++;
        end
      end else if (w >= 0) begin
        m_hold = 1'b1; m_byte = src_d[w]; m_gid = w; src_v[w] = 1'b0;
      end
      @(negedge clock);
    end
    $display("test_random done: %0d bytes transferred", sent);
  endtask
`else
  task automatic test_lock();
    logic [7:0] got [$];
    logic [7:0] exp_seq [4];
    int k0;
    exp_seq = '{8'h10, 8'h11, 8'h12, 8'h20};
    do_reset();
    k0 = 0; tx_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got.size() < 4; cyc++) begin
      req_valid = {1'b1, (k0 < 3)};
      req_data  = {8'h20, 8'(8'h10 + k0)};
      req_last  = {1'b1, (k0 == 2)};
      #1;
      if (tx_valid && tx_ready) got.push_back(tx_data);
      if (req_ready[0]) k0++;
      @(negedge clock);
    end
    checks++;
    if (got.size() != 4) begin
      errors++; $display("FAIL lock_count: got %0d bytes expected 4", got.size());
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_seq[i]) begin
        errors++; $display("FAIL lock_byte%0d: got %h expected %h", i, got[i], exp_seq[i]);
      end
      $display("lock byte %0d: %h", i, got[i]);
    end
  endtask

  task automatic test_lock_timeout();
    int hs, found;
    do_reset();
    hs = -1; found = -1; tx_ready = 1'b1;
    req_data = {8'h20, 8'h33}; req_last = 2'b10;
    for (int cyc = 0; cyc < T + 20; cyc++) begin
      req_valid = {1'b1, (cyc == 0)};
      #1;
      if (req_ready[1]) begin
        found = cyc;
        break;
      end
      if (tx_valid && tx_ready && hs < 0) hs = cyc;
      @(negedge clock);
    end
    checks++;
    if (hs < 0 || found < 0 || found - hs != T + 1) begin
      errors++; $display("FAIL lock_timeout: grant to req1 %0d cycles after handshake expected %0d",
                         found - hs, T + 1);
    end
    $display("test_lock_timeout done: handshake at %0d, requester 1 granted at %0d", hs, found);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_reset_xfer();
`ifndef UART_ARB_LOCK_EN
    test_random();
`else
    test_lock();
    test_lock_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
